// File: rtl/usrt_pkg.sv
// Shared APB transfer-state encodings, used by the requester-side master and
// the completer-side bus interface.
package usrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // Width of the ACCESS wait counter; TIMEOUT never exceeds its range.
  localparam int WAIT_W = 8;

endpackage : usrt_pkg

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns a one-cycle response pulse.
module apb_master
  import usrt_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              i_Pclk,
  input  logic              i_Presetn,

  input  logic              i_Cmd_Valid,
  output logic              o_Cmd_Ready,
  input  logic              i_Cmd_Write,
  input  logic [ADDR_W-1:0] i_Cmd_Addr,
  input  logic [DATA_W-1:0] i_Cmd_Wdata,

  output logic              o_Rsp_Valid,
  output logic [DATA_W-1:0] o_Rsp_Rdata,
  output logic              o_Rsp_Err,

  output logic [ADDR_W-1:0] o_Paddr,
  output logic              o_Psel,
  output logic              o_Penable,
  output logic              o_Pwrite,
  output logic [DATA_W-1:0] o_Pwdata,

  input  logic [DATA_W-1:0] i_Prdata,
  input  logic              i_Pready,
  input  logic              i_Pslverr
);

  // Count value held just before the edge on which the TIMEOUT-th wait lands.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  apb_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;

  // NOTE: every register here is state, so it is written only with <= inside
  // the one clocked block; blocking writes would race against readers.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      o_Cmd_Ready <= 1'b0;
      o_Rsp_Valid <= 1'b0;
      o_Rsp_Err   <= 1'b0;
      o_Rsp_Rdata <= '0;
      o_Paddr     <= '0;
      o_Psel      <= 1'b0;
      o_Penable   <= 1'b0;
      o_Pwrite    <= 1'b0;
      o_Pwdata    <= '0;
    end else begin
      o_Rsp_Valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          o_Cmd_Ready <= 1'b1;
          if (o_Cmd_Ready && i_Cmd_Valid) begin
            o_Paddr     <= i_Cmd_Addr;
            o_Pwrite    <= i_Cmd_Write;
            o_Pwdata    <= i_Cmd_Wdata;
            o_Psel      <= 1'b1;
            o_Penable   <= 1'b0;
            o_Cmd_Ready <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          o_Penable <= 1'b1;
          state     <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (i_Pready) begin
            o_Psel      <= 1'b0;
            o_Penable   <= 1'b0;
            o_Rsp_Valid <= 1'b1;
            o_Rsp_Err   <= i_Pslverr;
            o_Rsp_Rdata <= o_Pwrite ? '0 : i_Prdata;
            o_Cmd_Ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            // Counter stops at TIMEOUT, which always fits in WAIT_W bits.
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              o_Psel      <= 1'b0;
              o_Penable   <= 1'b0;
              o_Rsp_Valid <= 1'b1;
              o_Rsp_Err   <= 1'b1;
              o_Rsp_Rdata <= '0;
              o_Cmd_Ready <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end

        // NOTE: the unused encoding 2'b11 recovers to IDLE with the bus released
        // rather than relying on the synthesis tool's treatment of don't-cares.
        default: begin
          state       <= ST_IDLE;
          wait_cnt    <= '0;
          o_Cmd_Ready <= 1'b0;
          o_Paddr     <= '0;
          o_Psel      <= 1'b0;
          o_Penable   <= 1'b0;
          o_Pwrite    <= 1'b0;
          o_Pwdata    <= '0;
        end
      endcase
    end
  end

endmodule : apb_master
